// File: rtl/regfile_pkg.sv
// Shared types and defaults for the regfile_sb register file and its scoreboard.
package regfile_pkg;

   typedef enum logic [2:0] {
      WB_ALU  = 3'd0,
      WB_MEM  = 3'd1,
      WB_LINK = 3'd2,
      WB_CMP  = 3'd3,
      WB_IMM  = 3'd4
   } wb_sel_t;

   // Selects 5..7 never commit; WB_NONE is the canonical idle encoding.
   localparam logic [2:0] WB_NONE = 3'd5;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, outstanding counter, full and
// reject-error flags for long-latency destinations.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NREGS    = NREGS_DEF,
   parameter int unsigned MAX_PEND = 4,
   localparam int unsigned AW      = $clog2(NREGS)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             set_i,
   input  logic [AW-1:0]    set_addr_i,
   input  logic             clr_i,
   input  logic [AW-1:0]    clr_addr_i,
   output logic [NREGS-1:0] busy_o,
   output logic             full_o,
   output logic             err_o
);

   localparam int unsigned CW = $clog2(MAX_PEND + 1);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [CW-1:0]    count_q, count_d;
   logic             err_q, err_d;
   logic             clr_eff, same_addr, set_req, set_ok;

   assign full_o  = (count_q == CW'(MAX_PEND));
   assign busy_o  = busy_q;
   assign err_o   = err_q;

   assign clr_eff   = clr_i & busy_q[clr_addr_i];
   assign same_addr = clr_eff & (clr_addr_i == set_addr_i);
   assign set_req   = set_i & (set_addr_i != '0);
   // A same-address clear frees the slot it re-reserves, so it is legal even when full.
   assign set_ok    = set_req & (same_addr | (!busy_q[set_addr_i] & !full_o));

   always_comb begin
      busy_d = busy_q;
      if (clr_eff) begin
         busy_d[clr_addr_i] = 1'b0;
      end
      if (set_ok) begin
         busy_d[set_addr_i] = 1'b1;
      end
      count_d = count_q + CW'(set_ok) - CW'(clr_eff);
      err_d   = set_req & !set_ok;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-back mux, NUM_RD async read ports and pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: forward the committing write value to matching read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned NREGS    = NREGS_DEF,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned MAX_PEND = 4,
   localparam int unsigned AW      = $clog2(NREGS)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NUM_RD*AW-1:0]   rd_addr_i,
   output logic [NUM_RD*XLEN-1:0] rd_data_o,
   output logic [NUM_RD-1:0]      rd_busy_o,
   input  logic                   wr_en_i,
   input  logic [AW-1:0]          wr_addr_i,
   input  logic [2:0]             wr_sel_i,
   input  logic [XLEN-1:0]        alu_res_i,
   input  logic [XLEN-1:0]        mem_data_i,
   input  logic [XLEN-1:0]        imm_i,
   input  logic [XLEN-1:0]        pc_i,
   input  logic [1:0]             cmp_i,
   input  logic                   sb_set_i,
   input  logic [AW-1:0]          sb_addr_i,
   output logic                   sb_full_o,
   output logic                   sb_err_o,
   output logic [XLEN-1:0]        wb_bus_o
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  wb_bus_q;
   logic [XLEN-1:0]  wv;
   logic [NREGS-1:0] busy;
   logic             wb_commit, reg_commit, mem_commit;
   logic             unused_cmp;

   assign unused_cmp = cmp_i[1];

   always_comb begin
      wv = '0;
      case (wr_sel_i)
         WB_ALU:  wv = alu_res_i;
         WB_MEM:  wv = mem_data_i;
         WB_LINK: wv = pc_i + XLEN'(4);
         WB_CMP:  wv = {{(XLEN-1){1'b0}}, cmp_i[0]};
         WB_IMM:  wv = imm_i;
         default: wv = '0;
      endcase
   end

   // wb_bus tracks x0 commits too; only the storage write is suppressed for x0.
   assign wb_commit  = wr_en_i & (wr_sel_i <= 3'd4);
   assign reg_commit = wb_commit & (wr_addr_i != '0);
   assign mem_commit = reg_commit & (wr_sel_i == WB_MEM);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
         wb_bus_q <= '0;
      end else begin
         if (reg_commit) begin
            regs_q[wr_addr_i] <= wv;
         end
         if (wb_commit) begin
            wb_bus_q <= wv;
         end
      end
   end

   assign wb_bus_o = wb_bus_q;

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .MAX_PEND (MAX_PEND)
   ) u_sb (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .set_i      (sb_set_i),
      .set_addr_i (sb_addr_i),
      .clr_i      (mem_commit),
      .clr_addr_i (wr_addr_i),
      .busy_o     (busy),
      .full_o     (sb_full_o),
      .err_o      (sb_err_o)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic          hit;
      assign ra = rd_addr_i[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      assign hit = reg_commit & (wr_addr_i == ra);
`else
      assign hit = 1'b0;
`endif
      assign rd_data_o[i*XLEN +: XLEN] = (ra == '0) ? '0 : (hit ? wv : regs_q[ra]);
      assign rd_busy_o[i] = busy[ra] & (ra != '0) & !(hit & mem_commit);
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed corner cases then random traffic against a
// spec-level model (array of registers plus a set of reserved destinations).
module tb_regfile_sb;
   import regfile_pkg::*;

   localparam int XLEN = 32, NREGS = 32, AW = 5, NUM_RD = 2, MAX_PEND = 4;

   logic                   clk, rst_n;
   logic [NUM_RD*AW-1:0]   rd_addr;
   logic [NUM_RD*XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]      rd_busy;
   logic                   wr_en, sb_set, sb_full, sb_err;
   logic [AW-1:0]          wr_addr, sb_addr;
   logic [2:0]             wr_sel;
   logic [XLEN-1:0]        alu_res, mem_data, imm, pc, wb_bus;
   logic [1:0]             cmp;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] m_regs [NREGS];
   bit              m_busy [NREGS];
   logic [XLEN-1:0] m_wb;
   bit              m_err;

   regfile_sb #(
      .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .MAX_PEND(MAX_PEND)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
      .rd_busy_o(rd_busy), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_sel_i(wr_sel),
      .alu_res_i(alu_res), .mem_data_i(mem_data), .imm_i(imm), .pc_i(pc), .cmp_i(cmp),
      .sb_set_i(sb_set), .sb_addr_i(sb_addr), .sb_full_o(sb_full), .sb_err_o(sb_err),
      .wb_bus_o(wb_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int pend();
      int n = 0;
      for (int r = 0; r < NREGS; r++) n += int'(m_busy[r]);
      return n;
   endfunction

   function automatic logic [31:0] model_wv();
      case (wr_sel)
         3'd0: return alu_res;
         3'd1: return mem_data;
         3'd2: return pc + 32'd4;
         3'd3: return {31'd0, cmp[0]};
         3'd4: return imm;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NREGS; r++) begin
         m_regs[r] = '0;
         m_busy[r] = 1'b0;
      end
      m_wb  = '0;
      m_err = 1'b0;
   endtask

   task automatic idle();
      rd_addr = '0; wr_en = 0; wr_addr = '0; wr_sel = WB_NONE; alu_res = '0; mem_data = '0;
      imm = '0; pc = '0; cmp = '0; sb_set = 0; sb_addr = '0;
   endtask

   task automatic check_comb();
      for (int i = 0; i < NUM_RD; i++) begin
         int a;
         logic [31:0] ed;
         bit eb;
         a  = int'(rd_addr[i*AW +: AW]);
         ed = (a == 0) ? 32'd0 : m_regs[a];
         eb = (a != 0) && m_busy[a];
`ifdef REGFILE_BYPASS_EN
         if (wr_en && wr_sel <= 3'd4 && int'(wr_addr) == a && a != 0) begin
            ed = model_wv();
            if (wr_sel == 3'd1) eb = 1'b0;
         end
`endif
         chk($sformatf("rd_data%0d", i), rd_data[i*XLEN +: XLEN], ed);
         chk($sformatf("rd_busy%0d", i), 32'(rd_busy[i]), 32'(eb));
      end
      chk("sb_full", 32'(sb_full), 32'(pend() == MAX_PEND));
      chk("wb_bus", wb_bus, m_wb);
      chk("sb_err", 32'(sb_err), 32'(m_err));
   endtask

   // Called at a negedge with inputs set; returns at the following negedge.
   task automatic step();
      logic [31:0] wv;
      bit commit, clr, full, nerr;
      bit nb [NREGS];
      int wa, sa;
      #1;
      check_comb();
      wv     = model_wv();
      wa     = int'(wr_addr);
      sa     = int'(sb_addr);
      commit = wr_en && (wr_sel <= 3'd4);
      full   = (pend() == MAX_PEND);
      nb     = m_busy;
      clr    = commit && wr_sel == 3'd1 && wa != 0 && m_busy[wa];
      if (clr) nb[wa] = 1'b0;
      nerr = 1'b0;
      if (sb_set && sa != 0) begin
         if (clr && wa == sa) nb[sa] = 1'b1;
         else if (m_busy[sa] || full) nerr = 1'b1;
         else nb[sa] = 1'b1;
      end
      @(posedge clk);
      #1;
      if (commit) begin
         m_wb = wv;
         if (wa != 0) m_regs[wa] = wv;
      end
      m_busy = nb;
      m_err  = nerr;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rd_addr = {5'd3, 5'd1};
      step();

      // Write-back mux corners
      wr_en = 1; wr_sel = 3'd2; pc = 32'hFFFF_FFFC; wr_addr = 5'd1;
      step();
      wr_sel = 3'd3; cmp = 2'b11; wr_addr = 5'd2;
      step();
      wr_sel = 3'd0; alu_res = 32'hDEAD_BEEF; wr_addr = 5'd0;
      step();
      wr_en = 0; rd_addr = {5'd2, 5'd1};
      #1;
      chk("link_wrap_x1", rd_data[31:0], 32'd0);
      chk("cmp_x2", rd_data[63:32], 32'd1);
      chk("wb_x0_commit", wb_bus, 32'hDEAD_BEEF);
      step();
      rd_addr = '0;
      #1;
      chk("x0_reads_zero", rd_data[31:0], 32'd0);
      step();

      // Fill the scoreboard, then overflow
      sb_set = 1;
      for (int a = 5; a <= 8; a++) begin
         sb_addr = 5'(a);
         step();
      end
      sb_set = 0;
      #1;
      chk("sb_full_after4", 32'(sb_full), 32'd1);
      sb_set = 1; sb_addr = 5'd9; rd_addr = {5'd5, 5'd9};
      step();
      sb_set = 0;
      #1;
      chk("sb_err_pulse", 32'(sb_err), 32'd1);
      chk("x9_not_busy", 32'(rd_busy[0]), 32'd0);
      wr_en = 1; wr_sel = 3'd1; mem_data = 32'h55; wr_addr = 5'd5;
      step();
      wr_en = 0;
      #1;
      chk("full_drop", 32'(sb_full), 32'd0);
      chk("x5_busy_clear", 32'(rd_busy[1]), 32'd0);
      chk("sb_err_1cycle", 32'(sb_err), 32'd0);
      step();

      // Same-cycle clear and re-reserve of x3
      sb_set = 1; sb_addr = 5'd3;
      step();
      wr_en = 1; wr_sel = 3'd1; mem_data = 32'h33; wr_addr = 5'd3; rd_addr = {5'd3, 5'd3};
      step();
      wr_en = 0; sb_set = 0;
      #1;
      chk("x3_still_busy", 32'(rd_busy[0]), 32'd1);
      chk("x3_count_same", 32'(sb_full), 32'd1);
      chk("x3_no_err", 32'(sb_err), 32'd0);
      wr_en = 1; wr_sel = 3'd4; imm = 32'hA5A5; wr_addr = 5'd10;
      step();
      wr_en = 0;

      // Asynchronous reset mid-cycle
      rd_addr = {5'd5, 5'd3};
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_rd0", rd_data[31:0], 32'd0);
      chk("rst_rd1", rd_data[63:32], 32'd0);
      chk("rst_busy", 32'(rd_busy), 32'd0);
      chk("rst_full", 32'(sb_full), 32'd0);
      chk("rst_wb", wb_bus, 32'd0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      step();

      // Same-cycle read of a committing write
      wr_en = 1; wr_sel = 3'd0; alu_res = 32'h1234; wr_addr = 5'd4; rd_addr = {5'd0, 5'd4};
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_x4", rd_data[31:0], 32'h1234);
`else
      chk("nobypass_x4", rd_data[31:0], 32'd0);
`endif
      step();
      idle();

      // Random traffic biased to a few registers so the scoreboard saturates
      for (int n = 0; n < 10000; n++) begin
         rd_addr  = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
         wr_en    = ($urandom_range(0, 1) == 1);
         wr_addr  = 5'($urandom_range(0, 9));
         wr_sel   = 3'($urandom_range(0, 7));
         alu_res  = $urandom; mem_data = $urandom; imm = $urandom; pc = $urandom;
         cmp      = 2'($urandom);
         sb_set   = ($urandom_range(0, 4) < 2);
         sb_addr  = 5'($urandom_range(0, 9));
         step();
      end
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
